// File: rtl/skew_feeder_pkg.sv
// Shared constants, FSM state type and lane-delay helper for the skew feeder.
package skew_feeder_pkg;

  localparam logic N_2_S = 1'b0;
  localparam logic S_2_N = 1'b1;
  localparam logic W_2_E = 1'b0;
  localparam logic E_2_W = 1'b1;

  localparam int RSA_DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Extra cycles lane j waits beyond the one-cycle input register.
  function automatic int lane_delay(input int j, input int y, input logic d);
    return (d == S_2_N) ? (y - 1 - j) : j;
  endfunction

endpackage

// File: rtl/skew_feeder_if.sv
// Upstream vector stream into the skew feeder: valid/ready handshake plus direction.
interface skew_feeder_if
  import skew_feeder_pkg::*;
#(
  parameter int Y      = 4,
  parameter int RSA_DW = RSA_DW_DEF
);

  logic                  dir;
  logic                  in_valid;
  logic                  in_ready;
  logic [Y*RSA_DW-1:0]   in_data;
  logic                  in_last;

  modport master (output dir, in_valid, in_data, in_last, input in_ready);
  modport slave  (input dir, in_valid, in_data, in_last, output in_ready);

endinterface

// File: rtl/skew_delay_line.sv
// Per-lane register chain of {done, en, data}; output tap chosen by direction.
// Latency 1+TAP0 (sel=0) or 1+TAP1 (sel=1) cycles; no backpressure, always shifts.
module skew_delay_line #(
  parameter int DW   = 16,
  parameter int TAP0 = 0,
  parameter int TAP1 = 0
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          sel,
  input  logic [DW-1:0] in_data,
  input  logic          in_en,
  input  logic          in_done,
  output logic [DW-1:0] out_data,
  output logic          out_en,
  output logic          out_done
);

  localparam int DEPTH = ((TAP0 > TAP1) ? TAP0 : TAP1) + 1;

  logic [DEPTH-1:0][DW+1:0] chain;
  logic [DW+1:0]            tap;

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      chain <= '0;
    end else begin
      chain[0] <= {in_done, in_en, in_data};
      for (int k = 1; k < DEPTH; k++) begin
        chain[k] <= chain[k-1];
      end
    end
  end

  assign tap = sel ? chain[TAP1] : chain[TAP0];
  assign {out_done, out_en, out_data} = tap;

endmodule

// File: rtl/skew_feeder.sv
// Skews accepted vectors across Y PE columns (lane j delayed 1+d(j) cycles, d set by dir).
// in_ready drops for Y drain cycles after the last beat so packets never overlap.
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int Y      = 4,
  parameter int L      = 4,
  parameter int RSA_DW = RSA_DW_DEF
) (
  input  logic                clk,
  input  logic                sys_rst,
  skew_feeder_if.slave        s,
  output logic [Y*RSA_DW-1:0] B_data,
  output logic [Y-1:0]        new_cal_en,
  output logic [Y-1:0]        new_cal_done,
  output logic                busy,
  output logic                len_err
);

  localparam int CW  = $clog2(L + 1);
  localparam int DCW = $clog2(Y + 1);

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [DCW-1:0] dcnt, dcnt_nx;
  logic           dir_q, dir_nx;
  logic           len_err_nx;
  logic           accept;
  logic           at_limit;
  logic           beat_last;
  logic           force_last;

  assign s.in_ready = (state != DRAIN);
  assign accept     = s.in_valid && s.in_ready;
  // cnt holds beats accepted before this one, so L-1 means this is the L-th.
  assign at_limit   = (cnt == CW'(L - 1));
  assign beat_last  = s.in_last || at_limit;
  assign force_last = at_limit && !s.in_last;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dcnt    <= '0;
      dir_q   <= N_2_S;
      len_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      dcnt    <= dcnt_nx;
      dir_q   <= dir_nx;
      len_err <= len_err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    dcnt_nx    = dcnt;
    dir_nx     = dir_q;
    len_err_nx = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          dir_nx = s.dir;
          cnt_nx = CW'(1);
          if (beat_last) begin
            state_nx   = DRAIN;
            dcnt_nx    = '0;
            len_err_nx = force_last;
          end else begin
            state_nx = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          cnt_nx = cnt + CW'(1);
          if (beat_last) begin
            state_nx   = DRAIN;
            dcnt_nx    = '0;
            len_err_nx = force_last;
          end
        end
      end
      DRAIN: begin
        if (dcnt == DCW'(Y - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          dcnt_nx  = '0;
        end else begin
          dcnt_nx = dcnt + DCW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        dcnt_nx  = '0;
      end
    endcase
  end

  for (genvar j = 0; j < Y; j++) begin : g_lane
    localparam int D_NS = lane_delay(j, Y, N_2_S);
    localparam int D_SN = lane_delay(j, Y, S_2_N);

    logic [RSA_DW-1:0] lane_in;
    logic [RSA_DW-1:0] lane_out;

    // Idle cycles inject zeros so bubbles travel down the chain as zeros.
    assign lane_in = accept ? s.in_data[j*RSA_DW +: RSA_DW] : '0;

    skew_delay_line #(
      .DW   (RSA_DW),
      .TAP0 (D_NS),
      .TAP1 (D_SN)
    ) u_dl (
      .clk      (clk),
      .sys_rst  (sys_rst),
      .sel      (dir_q == S_2_N),
      .in_data  (lane_in),
      .in_en    (accept),
      .in_done  (accept && beat_last),
      .out_data (lane_out),
      .out_en   (new_cal_en[j]),
      .out_done (new_cal_done[j])
    );

    assign B_data[j*RSA_DW +: RSA_DW] = lane_out;
  end

endmodule
